// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch unit's instruction-memory read port and its decode-side instruction register.
// Master is the fetch unit. The slave side is instruction memory plus the decode stage.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-memory read channel
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_ack;
  logic [DATA_W-1:0] im_rdata;
  // instruction register towards decode
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output im_req, im_addr, ir, ir_pc, ir_valid,
    input  im_ack, im_rdata, ir_ready
  );

  modport slave (
    input  im_req, im_addr, ir, ir_pc, ir_valid,
    output im_ack, im_rdata, ir_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: fetches the word at PC into ir, pulses pc_en once per kept instruction, and supports flush.
// Latency: first im_req comes 1 cycle after IDLE; ir_valid is set on the edge that sees im_ack.
// Backpressure: ir is held until decode asserts ir_ready. Optional FETCH_TIMEOUT_EN adds an im_ack timeout and a sticky error.
module instr_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     PC,
  output logic                  pc_en,
  input  logic                  flush,
  instr_fetch_unit_if.master    bus,
  output logic [31:0]           fetch_cnt,
  output logic                  fetch_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT must be >= 1");
  end

  logic [1:0] state;
  // Set when a flush arrives during REQ. The pending read still has to complete, and its data is dropped.
  logic       drop;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer;
  logic          err_q;
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Advance the PC only when the returned word is actually kept.
  always_comb begin
    pc_en = (state == REQ) & bus.im_ack & ~drop & ~flush;
  end

  // Fetch FSM: request, capture, hold for decode, and flush/timeout handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      drop         <= 1'b0;
      bus.im_req   <= 1'b0;
      bus.im_addr  <= '0;
      bus.ir       <= '0;
      bus.ir_pc    <= '0;
      bus.ir_valid <= 1'b0;
      fetch_cnt    <= '0;
`ifdef FETCH_TIMEOUT_EN
      timer        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!flush) begin
            bus.im_addr <= PC;
            bus.im_req  <= 1'b1;
            state       <= REQ;
`ifdef FETCH_TIMEOUT_EN
            timer       <= '0;
`endif
          end
        end
        REQ: begin
          if (bus.im_ack) begin
            bus.im_req <= 1'b0;
            drop       <= 1'b0;
            if (drop || flush) begin
              // The redirected PC is refetched from IDLE.
              state <= IDLE;
            end else begin
              bus.ir       <= bus.im_rdata;
              bus.ir_pc    <= bus.im_addr;
              bus.ir_valid <= 1'b1;
              state        <= HOLD;
            end
          end else begin
            if (flush) drop <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            if (timer == TW'(TIMEOUT - 1)) begin
              bus.im_req <= 1'b0;
              err_q      <= 1'b1;
              state      <= ERR;
            end else begin
              timer <= timer + 1'b1;
            end
`endif
          end
        end
        HOLD: begin
          if (flush) begin
            bus.ir_valid <= 1'b0;
            state        <= IDLE;
          end else if (bus.ir_ready) begin
            fetch_cnt    <= fetch_cnt + 32'd1;
            bus.ir_valid <= 1'b0;
            bus.im_addr  <= PC;
            bus.im_req   <= 1'b1;
            state        <= REQ;
`ifdef FETCH_TIMEOUT_EN
            timer        <= '0;
`endif
          end
        end
        ERR: begin
          // Only reset leaves ERR. flush has no effect here.
          state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch, backpressure, flush in REQ/HOLD, counter wrap, and no-ack wait.
// Inputs are driven 1 time unit after each rising edge. Outputs are checked after a further settle delay.
// Expected values are written by hand from the block's behaviour.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC;
  logic        pc_en;
  logic        flush;
  logic [31:0] fetch_cnt;
  logic        fetch_err;
  int          checks = 0;
  int          errors = 0;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PC        (PC),
    .pc_en     (pc_en),
    .flush     (flush),
    .bus       (bus.master),
    .fetch_cnt (fetch_cnt),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; PC = 32'h0; flush = 1'b0;
    bus.im_ack = 1'b0; bus.im_rdata = 32'h0; bus.ir_ready = 1'b0;
    #3;
    chk("rst_im_req", 64'(bus.im_req), 64'd0);
    chk("rst_im_addr", 64'(bus.im_addr), 64'd0);
    chk("rst_ir", 64'(bus.ir), 64'd0);
    chk("rst_ir_pc", 64'(bus.ir_pc), 64'd0);
    chk("rst_ir_valid", 64'(bus.ir_valid), 64'd0);
    chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst_fetch_err", 64'(fetch_err), 64'd0);
    chk("rst_pc_en", 64'(pc_en), 64'd0);
    #4 rst_n = 1'b1;

    // First fetch at PC=0. Memory acknowledges 2 cycles after im_req rises.
    tick();
    chk("f1_im_req", 64'(bus.im_req), 64'd1);
    chk("f1_im_addr", 64'(bus.im_addr), 64'd0);
    chk("f1_pc_en_idle", 64'(pc_en), 64'd0);
    tick();
    chk("f1_pc_en_wait", 64'(pc_en), 64'd0);
    bus.im_ack = 1'b1; bus.im_rdata = 32'h12345678; #1;
    chk("f1_pc_en_ack", 64'(pc_en), 64'd1);
    tick();
    bus.im_ack = 1'b0; PC = 32'h4; #1;
    chk("f1_ir", 64'(bus.ir), 64'h12345678);
    chk("f1_ir_pc", 64'(bus.ir_pc), 64'd0);
    chk("f1_ir_valid", 64'(bus.ir_valid), 64'd1);
    chk("f1_im_req_low", 64'(bus.im_req), 64'd0);
    chk("f1_pc_en_after", 64'(pc_en), 64'd0);

    // Decode stalls for 5 cycles, then accepts.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ir", 64'(bus.ir), 64'h12345678);
      chk("hold_valid", 64'(bus.ir_valid), 64'd1);
      chk("hold_pc_en", 64'(pc_en), 64'd0);
    end
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0; #1;
    chk("acc_fetch_cnt", 64'(fetch_cnt), 64'd1);
    chk("acc_im_addr", 64'(bus.im_addr), 64'h4);
    chk("acc_im_req", 64'(bus.im_req), 64'd1);
    chk("acc_ir_valid", 64'(bus.ir_valid), 64'd0);
    chk("acc_ir_kept", 64'(bus.ir), 64'h12345678);

    // Flush during REQ. The late ack is discarded and the fetch restarts at 0x100.
    tick();
    flush = 1'b1; #1;
    chk("fl_pc_en_flush", 64'(pc_en), 64'd0);
    tick();
    flush = 1'b0; PC = 32'h100;
    tick();
    tick();
    bus.im_ack = 1'b1; bus.im_rdata = 32'hDEADBEEF; #1;
    chk("fl_pc_en_drop", 64'(pc_en), 64'd0);
    tick();
    bus.im_ack = 1'b0; #1;
    chk("fl_im_req_idle", 64'(bus.im_req), 64'd0);
    chk("fl_ir_valid", 64'(bus.ir_valid), 64'd0);
    chk("fl_ir_kept", 64'(bus.ir), 64'h12345678);
    tick();
    chk("fl_refetch_req", 64'(bus.im_req), 64'd1);
    chk("fl_refetch_addr", 64'(bus.im_addr), 64'h100);

    // Flush and ir_ready together in HOLD. Flush wins.
    bus.im_ack = 1'b1; bus.im_rdata = 32'hCAFE0001; #1;
    chk("fh_pc_en", 64'(pc_en), 64'd1);
    tick();
    bus.im_ack = 1'b0; PC = 32'h200; #1;
    chk("fh_ir", 64'(bus.ir), 64'hCAFE0001);
    chk("fh_ir_pc", 64'(bus.ir_pc), 64'h100);
    flush = 1'b1; bus.ir_ready = 1'b1;
    tick();
    flush = 1'b0; bus.ir_ready = 1'b0; #1;
    chk("fh_ir_valid", 64'(bus.ir_valid), 64'd0);
    chk("fh_fetch_cnt", 64'(fetch_cnt), 64'd1);
    chk("fh_im_req_idle", 64'(bus.im_req), 64'd0);
    tick();
    chk("fh_refetch_addr", 64'(bus.im_addr), 64'h200);
    chk("fh_refetch_req", 64'(bus.im_req), 64'd1);

    // fetch_cnt wraps from 0xFFFFFFFF to 0.
    bus.im_ack = 1'b1; bus.im_rdata = 32'h0BADF00D;
    tick();
    bus.im_ack = 1'b0; PC = 32'h204;
    force dut.fetch_cnt = 32'hFFFFFFFF;
    #1;
    release dut.fetch_cnt;
    #1;
    chk("wr_preload", 64'(fetch_cnt), 64'hFFFFFFFF);
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0; #1;
    chk("wr_fetch_cnt", 64'(fetch_cnt), 64'd0);
    chk("wr_im_addr", 64'(bus.im_addr), 64'h204);

    // No ack ever arrives.
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_req_wait", 64'(bus.im_req), 64'd1);
      chk("to_err_wait", 64'(fetch_err), 64'd0);
    end
    tick();
    chk("to_req_drop", 64'(bus.im_req), 64'd0);
    chk("to_err_set", 64'(fetch_err), 64'd1);
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("to_err_sticky", 64'(fetch_err), 64'd1);
      chk("to_err_no_req", 64'(bus.im_req), 64'd0);
    end
    flush = 1'b0;
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("nt_im_req", 64'(bus.im_req), 64'd1);
      chk("nt_fetch_err", 64'(fetch_err), 64'd0);
    end
`endif

    // Asynchronous reset in the middle of operation.
    rst_n = 1'b0; #1;
    chk("rst2_im_req", 64'(bus.im_req), 64'd0);
    chk("rst2_fetch_err", 64'(fetch_err), 64'd0);
    chk("rst2_fetch_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst2_ir", 64'(bus.ir), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
